// File: rtl/led7seg_scan.sv
// Multiplexed DIGITS-wide 7-segment driver: scan prescaler, hex decode, dp, per-digit blanking and leading-zero blanking.
// LED/SA are registered: 1-clock latency from D/DP/EN/LZB and idx; no handshake, inputs are sampled every clock.
module led7seg_scan #(
  parameter int DIGITS         = 4,
  parameter int DIV            = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [4*DIGITS-1:0]   D,
  input  logic [DIGITS-1:0]     DP,
  input  logic [DIGITS-1:0]     EN,
  input  logic                  LZB,
  output logic [7:0]            LED,
  output logic [DIGITS-1:0]     SA
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [7:0]        LED_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SA_OFF  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [7:0]        led_q, led_d;
  logic [DIGITS-1:0] sa_q,  sa_d;

  logic [3:0]        nib;
  logic              dp_bit;
  logic              en_bit;
  logic              upper_zero;
  logic              zero_run;
  logic              blank;
  logic [DIGITS-1:0] onehot;
  logic [7:0]        seg_word;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Prescaler: idx advances once every DIV clocks and wraps at DIGITS-1.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CW'(DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // Walk digits from the top so zero_run holds "all nibbles DIGITS-1..k are zero" at digit k.
  always_comb begin
    nib        = 4'h0;
    dp_bit     = 1'b0;
    en_bit     = 1'b0;
    upper_zero = 1'b0;
    zero_run   = 1'b1;
    onehot     = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (D[4*k +: 4] == 4'h0);
      if (idx_q == IW'(k)) begin
        nib        = D[4*k +: 4];
        dp_bit     = DP[k];
        en_bit     = EN[k];
        upper_zero = zero_run;
        onehot[k]  = 1'b1;
      end
    end

    blank    = !en_bit || (LZB && (idx_q != '0) && upper_zero);
    seg_word = blank ? 8'h00 : {dp_bit, hex2seg(nib)};
    led_d    = (SEG_ACTIVE_LOW != 0) ? ~seg_word : seg_word;
    sa_d     = blank ? '0 : onehot;
    if (AN_ACTIVE_LOW != 0) begin
      sa_d = ~sa_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
      idx_q <= '0;
      led_q <= LED_OFF;
      sa_q  <= SA_OFF;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      led_q <= led_d;
      sa_q  <= sa_d;
    end
  end

  assign LED = led_q;
  assign SA  = sa_q;

endmodule

// File: tb/tb_led7seg_scan.sv
// Bench for led7seg_scan (DIGITS=4, DIV=4, active-low segments and anodes): directed literal checks plus random stimulus
// compared every cycle against a slot-arithmetic reference model.
module tb_led7seg_scan;

  localparam int NDIG = 4;
  localparam int NDIV = 4;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic [15:0]       D = 16'h1234;
  logic [3:0]        DP = 4'h0;
  logic [3:0]        EN = 4'hF;
  logic              LZB = 1'b0;
  logic [7:0]        LED;
  logic [3:0]        SA;

  int checks = 0;
  int failures = 0;

  led7seg_scan #(
    .DIGITS(NDIG), .DIV(NDIV), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .D(D), .DP(DP), .EN(EN), .LZB(LZB), .LED(LED), .SA(SA)
  );

  always #5 CLK = ~CLK;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference: the k-th clock edge after reset release shows digit (k/DIV) mod DIGITS.
  int         n_edges = 0;
  logic [7:0] exp_led = 8'hFF;
  logic [3:0] exp_sa  = 4'hF;
  bit         armed   = 1'b0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      n_edges = 0;
      exp_led = 8'hFF;
      exp_sa  = 4'hF;
    end else begin
      int  dig;
      bit  blank;
      logic [7:0] word;
      dig   = (n_edges / NDIV) % NDIG;
      blank = (EN[dig] == 1'b0) || (LZB && dig > 0 && ((D >> (4 * dig)) == 16'h0));
      word  = blank ? 8'h00 : {DP[dig], seg_tab[(D >> (4 * dig)) & 16'hF]};
      exp_led = ~word;
      exp_sa  = blank ? 4'hF : ~(4'b0001 << dig);
      n_edges++;
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (armed) begin
      chk("model_led", LED, exp_led);
      chk("model_sa", {4'h0, SA}, {4'h0, exp_sa});
    end
  end

  // Async reset pulse landing between clock edges; released on a falling edge.
  task automatic do_reset();
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    chk("rst_led", LED, 8'hFF);
    chk("rst_sa", {4'h0, SA}, 8'h0F);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic run_slots(input string nm, input logic [15:0] sa_exp, input logic [31:0] led_exp);
    do_reset();
    for (int e = 0; e < 17; e++) begin
      int s;
      @(posedge CLK);
      #1;
      s = (e / NDIV) % NDIG;
      chk({nm, "_sa"}, {4'h0, SA}, {4'h0, sa_exp[4*s +: 4]});
      chk({nm, "_led"}, LED, led_exp[8*s +: 8]);
    end
  endtask

  initial begin
    #1;
    armed = 1'b1;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("first_edge_sa", {4'h0, SA}, 8'h0E);
    chk("first_edge_led", LED, 8'h99);
    repeat (6) @(posedge CLK);

    D = 16'h1234; EN = 4'hF; DP = 4'h0; LZB = 1'b0;
    run_slots("scan", 16'h7BDE, 32'hF9A4B099);

    for (int v = 15; v >= 0; v--) begin
      logic [7:0] spot;
      D = 16'(v);
      do_reset();
      @(posedge CLK);
      #1;
      case (v)
        0:       spot = 8'hC0;
        1:       spot = 8'hF9;
        8:       spot = 8'h80;
        15:      spot = 8'h8E;
        default: spot = 8'h00;
      endcase
      if (spot != 8'h00) chk("decode_spot", LED, spot);
    end

    D = 16'h0050; LZB = 1'b1;
    run_slots("lzb_0050", 16'hFFDE, 32'hFFFF92C0);
    D = 16'h0000;
    run_slots("lzb_0000", 16'hFFFE, 32'hFFFFFFC0);

    D = 16'h1234; LZB = 1'b0; DP = 4'b0010;
    run_slots("dp", 16'h7BDE, 32'hF9A43099);
    DP = 4'h0; EN = 4'b1011;
    run_slots("en", 16'h7FDE, 32'hF9FFB099);
    EN = 4'hF;

    do_reset();
    @(posedge CLK);
    #1;
    chk("live_before", LED, 8'h99);
    D = 16'h1237;
    for (int e = 1; e < 4; e++) begin
      @(posedge CLK);
      #1;
      chk("live_led", LED, 8'hF8);
      chk("live_sa", {4'h0, SA}, 8'h0E);
    end
    @(posedge CLK);
    #1;
    chk("live_next_sa", {4'h0, SA}, 8'h0D);

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge CLK);
      #1;
      if ($urandom_range(0, 7) == 0) begin
        D   = 16'($urandom);
        case ($urandom_range(0, 3))
          0:       D = D & 16'h00FF;
          1:       D = D & 16'h000F;
          2:       D = 16'h0000;
          default: ;
        endcase
        DP  = 4'($urandom);
        EN  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
        LZB = 1'($urandom);
      end
      if ($urandom_range(0, 299) == 0) begin
        #2;
        RST_N = 1'b0;
        #1;
        chk("rand_rst_led", LED, 8'hFF);
        chk("rand_rst_sa", {4'h0, SA}, 8'h0F);
        @(negedge CLK);
        RST_N = 1'b1;
      end
    end

    @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led7seg_scan.md
Name: led7seg_scan

Overview:
- Parametrised successor to the single-digit 7-segment decoder.
- Drives DIGITS multiplexed common-anode/cathode 7-segment digits from a packed hex bus.
- Built-in scan prescaler, per-digit decimal point, per-digit blank enable, and leading-zero blanking.
- Sits between the datapath (value to display) and the board LED pins (LED segments, SA anode selects).

Parameters:
- DIGITS, 4: number of multiplexed digits; legal range 1..8.
- DIV, 50000: clocks per digit slot; legal range >= 1. DIV=1 advances the digit every clock.
- SEG_ACTIVE_LOW, 1: 1 = segment on when LED bit is 0; 0 = segment on when LED bit is 1.
- AN_ACTIVE_LOW, 1: 1 = digit selected when SA bit is 0; 0 = digit selected when SA bit is 1.

Ports:
- CLK  input  1  system clock; all state rises on posedge.
- RST_N  input  1  asynchronous, active-low reset.
- D  input  4*DIGITS  hex nibbles; digit k = D[4k+3:4k]; digit 0 is least significant (rightmost).
- DP  input  DIGITS  decimal point request per digit; 1 = lit.
- EN  input  DIGITS  per-digit enable; 0 forces that digit blank.
- LZB  input  1  leading-zero blanking enable.
- LED  output  8  segments: LED[0]=a, LED[1]=b, LED[2]=c, LED[3]=d, LED[4]=e, LED[5]=f, LED[6]=g, LED[7]=dp.
- SA  output  DIGITS  one-hot digit select (polarity per AN_ACTIVE_LOW).

Behaviour:
- Reset (RST_N=0, asynchronous, immediate):
  - prescaler count = 0, digit index idx = 0.
  - LED = all segments off (8'hFF when SEG_ACTIVE_LOW=1).
  - SA = all digits deselected (all 1s when AN_ACTIVE_LOW=1).
- Reset asserted mid-scan: outputs go to the reset values immediately, without waiting for CLK.
- Prescaler:
  - cnt counts 0..DIV-1; tick = (cnt == DIV-1).
  - On tick: cnt <= 0 and idx <= (idx == DIGITS-1) ? 0 : idx+1. Otherwise cnt <= cnt+1.
  - Each digit is therefore selected for exactly DIV clocks; idx wraps DIGITS-1 -> 0.
- Output register:
  - LED and SA are registered every clock from the current idx and the current D/DP/EN/LZB.
  - Latency is 1 clock: an input change is visible on the next edge, with no wait for tick.
  - On the first edge after reset release, digit 0 is displayed.
- Hex decode, active-high g..a, in bits [6:0]:
  - 0=7'h3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - dp bit = DP[idx].
  - The whole 8-bit word is inverted when SEG_ACTIVE_LOW=1.
- Blanking:
  - Digit k is blank if EN[k]=0, or if LZB=1 and k>0 and nibbles DIGITS-1 down to k are all zero.
  - Digit 0 is never removed by LZB, so an all-zero value shows a single 0.
  - A blank digit drives SA all deselected and LED all off (dp also off) for its whole slot.
  - idx still advances through blank digits, so the scan period stays constant.
- SA select: when not blank, SA = one-hot of idx, inverted if AN_ACTIVE_LOW=1. Exactly one digit is selected at a time.
- DIGITS=1: idx stays 0; SA is constant-selected unless that digit is blank.
- Widths:
  - cnt is $clog2(DIV) bits, minimum 1.
  - idx is $clog2(DIGITS) bits, minimum 1.
  - No overflow is permitted past DIV-1 or DIGITS-1.

Test Plan:
All scenarios use DIGITS=4, DIV=4, SEG_ACTIVE_LOW=1, AN_ACTIVE_LOW=1.
1. Reset: pulse RST_N low between clock edges mid-scan -> LED=8'hFF and SA=4'hF immediately. After release, the first edge gives SA=4'b1110.
2. Scan order: D=16'h1234, EN=4'hF, DP=0, LZB=0 -> each row holds 4 clocks, then wraps to SA=1110:
   - SA=1110 with LED=8'h99
   - SA=1101 with LED=8'hB0
   - SA=1011 with LED=8'hA4
   - SA=0111 with LED=8'hF9
3. Decode sweep: step D[3:0] through F..0 while digit 0 is selected -> LED[6:0] is the inverse of the table. Spot checks: 0 -> 8'hC0, 1 -> 8'hF9, 8 -> 8'h80, F -> 8'h8E.
4. Leading-zero blanking, LZB=1:
   - D=16'h0050 -> digits 3 and 2 give SA=4'hF and LED=8'hFF in their slots; digit 1 gives 8'h92; digit 0 gives 8'hC0.
   - D=16'h0000 -> only digit 0 is lit, with 8'hC0.
5. DP and EN: DP=4'b0010 -> digit 1 LED[7]=0 and all others LED[7]=1. EN=4'b1011 -> the digit-2 slot shows SA=4'hF and LED=8'hFF, and the slot still lasts 4 clocks.
6. Live update: change D[3:0] from 4 to 7 in the middle of the digit-0 slot -> LED changes from 8'h99 to 8'hF8 one clock later, and SA and the slot timing are unchanged.
